cell_eval_sched: RTL

//  Sequencer for the 96-bit cell datapath (mux/invert cell plus 2-bit AND cell).

---
 rtl/cell_sched_pkg.sv | 25 ++
 rtl/cell_sched_fifo.sv | 51 +++++
 rtl/cell_eval_sched.sv | 102 ++++++++++
 3 files changed

// File: rtl/cell_sched_pkg.sv
// Shared types and the combinational cell function for the cell evaluation sequencer.
package cell_sched_pkg;

  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_e;

  localparam int OUT_C0_BIT = 32;
  localparam int SEL_BIT    = 93;
  localparam int A_BIT      = 78;
  localparam int B_BIT      = 2;
  localparam int AND_HI_BIT = 14;
  localparam int AND_LO_BIT = 11;

  // Mux/invert cell feeding a 2-bit AND cell; every other result bit stays zero.
  function automatic logic [95:0] cell_eval(input logic [95:0] w);
    logic        c0;
    logic [95:0] r;
    c0            = ~(w[SEL_BIT] ? w[A_BIT] : w[B_BIT]);
    r             = '0;
    r[OUT_C0_BIT] = c0;
    r[1]          = w[AND_HI_BIT] & c0;
    r[0]          = w[AND_LO_BIT] & c0;
    return r;
  endfunction

endpackage

// File: rtl/cell_sched_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module cell_sched_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 96
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/cell_eval_sched.sv
// Buffers stimulus words, evaluates each over a fixed window and holds the
// registered result until the sink takes it.
module cell_eval_sched
  import cell_sched_pkg::*;
#(
  parameter int DATA_W      = 96,
  parameter int DEPTH       = 4,
  parameter int EVAL_CYCLES = 2
) (
  input  logic              clkin_data,
  input  logic              rst_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [15:0]       eval_count
);

  localparam int CW = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(EVAL_CYCLES - 1);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] w_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic [15:0]       eval_cnt_q, eval_cnt_d;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [DATA_W-1:0] fifo_dout;

  cell_sched_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk_i   (clkin_data),
    .rst_i   (rst_data),
    .push_i  (in_valid && !fifo_full),
    .data_i  (in_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Head leaves the FIFO whenever the FSM is free to start a new word.
  assign fifo_pop = !fifo_empty &&
                    ((state_q == IDLE) || ((state_q == HOLD) && out_ready));

  assign eval_cnt_d = eval_cnt_q + {15'd0, out_valid_q && out_ready};

  always_ff @(posedge clkin_data) begin
    if (rst_data) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      w_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      eval_cnt_q  <= '0;
    end else begin
      eval_cnt_q <= eval_cnt_d;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            w_q     <= fifo_dout;
            cnt_q   <= CNT_RELOAD;
            state_q <= EVAL;
          end
        end
        EVAL: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            out_data_q  <= cell_eval(w_q);
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (!fifo_empty) begin
              w_q     <= fifo_dout;
              cnt_q   <= CNT_RELOAD;
              state_q <= EVAL;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = !fifo_full;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign eval_count = eval_cnt_q;

endmodule
